// File: rtl/stereo_pkg.sv
// stereo_pkg: definitions shared by the stereo-matching custom instructions.
// Holds the opcode map, default cost width / disparity range, the busy-FSM
// state type and the result-word field positions used by the driver header.
package stereo_pkg;

   // Defaults for the WTA selector parameters.
   localparam int unsigned DEF_COST_W   = 16;
   localparam int unsigned DEF_MAX_DISP = 64;

   // Opcodes carried on iOp.
   localparam logic [3:0] OP_CLR   = 4'h1;
   localparam logic [3:0] OP_PUSH  = 4'h2;
   localparam logic [3:0] OP_RATIO = 4'h3;
   localparam logic [3:0] OP_THR   = 4'h4;
   localparam logic [3:0] OP_RES   = 4'h8;
   localparam logic [3:0] OP_SEC   = 4'h9;
   localparam logic [3:0] OP_NBR   = 4'hA;
   localparam logic [3:0] OP_CNT   = 4'hB;

   // Field positions of the OP_RES result word.
   localparam int unsigned RES_VALID_BIT = 31;
   localparam int unsigned RES_OVF_BIT   = 30;
   localparam int unsigned RES_BEST_LSB  = 8;
   localparam int unsigned RES_DISP_LSB  = 0;

   // Busy FSM of the custom instruction.
   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StMul
   } wtaState_t;

endpackage

// File: rtl/wta_uniq_check.sv
// wta_uniq_check: registered uniqueness test for the winner-take-all selector.
// On iLoad the two scaled costs 16*second and (16+ratio)*best are registered;
// oUniq compares those registers, so it is valid one enabled cycle after load.
// Ports:
//   iClk, iReset      clock, asynchronous active-high reset
//   iClk_en           clock enable, low holds the product registers
//   iLoad             capture the products from iBest/iSecond/iRatio
//   iBest, iSecond    best and second-best costs
//   iRatio            uniqueness ratio in 1/16 steps (0 disables the test)
//   oUniq             1 when the best cost is unique enough
module wta_uniq_check
   import stereo_pkg::*;
#(
   parameter int unsigned COST_W = DEF_COST_W
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic              iClk_en,
   input  logic              iLoad,
   input  logic [COST_W-1:0] iBest,
   input  logic [COST_W-1:0] iSecond,
   input  logic [7:0]        iRatio,
   output logic              oUniq
);

   // (16 + 255) * (2^COST_W - 1) fits in COST_W + 9 bits, so neither product overflows.
   localparam int unsigned PW = COST_W + 9;

   logic [8:0]    scale;
   logic [PW-1:0] rLhs;
   logic [PW-1:0] rRhs;
   logic          rRatioZero;

   assign scale = 9'd16 + {1'b0, iRatio};

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         rLhs       <= '0;
         rRhs       <= '0;
         rRatioZero <= 1'b1;
      end else if (iClk_en && iLoad) begin
         rLhs       <= PW'(iSecond) << 4;
         rRhs       <= PW'(iBest) * PW'(scale);
         rRatioZero <= (iRatio == 8'd0);
      end
   end

   assign oUniq = rRatioZero || (rLhs > rRhs);

endmodule

// File: rtl/disparity_wta.sv
// disparity_wta: winner-take-all disparity selector (Nios II multicycle custom
// instruction). Software pushes one cost per disparity in ascending order; the
// block keeps best / second-best costs and the costs either side of the best.
// Ports:
//   iClk, iReset   clock, asynchronous active-high reset
//   iClk_en        custom-instruction clock enable; low freezes all state
//   iStart         one-cycle instruction start strobe
//   iOp            opcode (see stereo_pkg)
//   iA             operand, sampled in the iStart cycle
//   oDone          one-cycle completion pulse
//   oRes           registered result, held until the next completion
module disparity_wta
   import stereo_pkg::*;
#(
   parameter int unsigned MAX_DISP = DEF_MAX_DISP,
   parameter int unsigned COST_W   = DEF_COST_W
) (
   input  logic        iClk,
   input  logic        iReset,
   input  logic        iClk_en,
   input  logic        iStart,
   input  logic [3:0]  iOp,
   input  logic [31:0] iA,
   output logic        oDone,
   output logic [31:0] oRes
);

   localparam logic [COST_W-1:0] COST_ONES = '1;
   localparam logic [8:0]        MAX_CNT   = 9'(MAX_DISP);

   wtaState_t rState, nState;

   logic [COST_W-1:0] rBest, rSecond, rLeft, rRight, rPrev, rThr;
   logic [COST_W-1:0] nBest, nSecond, nLeft, nRight, nPrev, nThr;
   logic [7:0]        rDisp, nDisp, rRatio, nRatio;
   logic [8:0]        rCnt, nCnt;
   logic              rPendR, nPendR, rOvf, nOvf;
   logic              nDone;
   logic [31:0]       nRes;

   logic              accept;     // instruction taken this cycle
   logic              finishRes;  // second stage of OP_RES completes this cycle
   logic              uniq;
   logic [COST_W-1:0] cost;
   logic [31:0]       resWord;

   assign cost = iA[COST_W-1:0];

   // Operand bits above the cost field are not used by any opcode.
   generate
      if (COST_W < 32) begin : gUnusedA
         logic unusedA;
         assign unusedA = ^iA[31:COST_W];
      end
   endgenerate

   // ---------------------------------------------------------------- busy FSM
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         rState <= StIdle;
      end else if (iClk_en) begin
         rState <= nState;
      end
   end

   always_comb begin
      nState = rState;
      unique case (rState)
         StIdle:  if (iStart) nState = (iOp == OP_RES) ? StMul : StExec;
         StMul:   nState = StExec;
         StExec:  nState = StIdle;
         default: nState = StIdle;
      endcase
   end

   always_comb begin
      accept    = 1'b0;
      finishRes = 1'b0;
      if (iClk_en) begin
         accept    = iStart && (rState == StIdle);
         finishRes = (rState == StMul);
      end
   end

   // ------------------------------------------------------- uniqueness stage
   wta_uniq_check #(
      .COST_W (COST_W)
   ) uUniq (
      .iClk    (iClk),
      .iReset  (iReset),
      .iClk_en (iClk_en),
      .iLoad   (accept && (iOp == OP_RES)),
      .iBest   (rBest),
      .iSecond (rSecond),
      .iRatio  (rRatio),
      .oUniq   (uniq)
   );

   // State cannot change while in StMul, so the live registers are still the
   // values the products were taken from.
   always_comb begin
      resWord                       = '0;
      resWord[RES_VALID_BIT]        = (rCnt != '0) && (rBest <= rThr) && uniq;
      resWord[RES_OVF_BIT]          = rOvf;
      resWord[RES_BEST_LSB +: 16]   = 16'(rBest);
      resWord[RES_DISP_LSB +: 8]    = rDisp;
   end

   // ------------------------------------------------------------- datapath
   always_comb begin
      nBest   = rBest;
      nSecond = rSecond;
      nLeft   = rLeft;
      nRight  = rRight;
      nPrev   = rPrev;
      nThr    = rThr;
      nDisp   = rDisp;
      nRatio  = rRatio;
      nCnt    = rCnt;
      nPendR  = rPendR;
      nOvf    = rOvf;
      nDone   = 1'b0;
      nRes    = oRes;

      if (accept) begin
         if (iOp != OP_RES) begin
            nDone = 1'b1;
            nRes  = '0;
         end
         case (iOp)
            OP_CLR: begin
               nBest   = COST_ONES;
               nSecond = COST_ONES;
               nLeft   = COST_ONES;
               nRight  = COST_ONES;
               nPrev   = '0;
               nCnt    = '0;
               nDisp   = '0;
               nPendR  = 1'b0;
               nOvf    = 1'b0;
            end
            OP_PUSH: begin
               if (rCnt == MAX_CNT) begin
                  nOvf = 1'b1;
               end else begin
                  // Right neighbour of the current best is the cost pushed just after it.
                  if (rPendR) begin
                     nRight = cost;
                     nPendR = 1'b0;
                  end
                  // Strict compare: on ties the lowest disparity wins.
                  if (cost < rBest) begin
                     nSecond = rBest;
                     nBest   = cost;
                     nDisp   = rCnt[7:0];
                     nLeft   = (rCnt == '0) ? COST_ONES : rPrev;
                     nRight  = COST_ONES;
                     nPendR  = 1'b1;
                  end else if (cost < rSecond) begin
                     nSecond = cost;
                  end
                  nPrev = cost;
                  nCnt  = rCnt + 9'd1;
               end
            end
            OP_RATIO: nRatio = iA[7:0];
            OP_THR:   nThr   = cost;
            OP_SEC:   nRes   = 32'(rSecond);
            OP_NBR:   nRes   = {16'(rLeft), 16'(rRight)};
            OP_CNT:   nRes   = 32'(rCnt);
            default:  ;
         endcase
      end else if (finishRes) begin
         nDone = 1'b1;
         nRes  = resWord;
      end
   end

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         rBest   <= COST_ONES;
         rSecond <= COST_ONES;
         rLeft   <= COST_ONES;
         rRight  <= COST_ONES;
         rPrev   <= '0;
         rThr    <= COST_ONES;
         rDisp   <= '0;
         rRatio  <= '0;
         rCnt    <= '0;
         rPendR  <= 1'b0;
         rOvf    <= 1'b0;
         oDone   <= 1'b0;
         oRes    <= '0;
      end else if (iClk_en) begin
         rBest   <= nBest;
         rSecond <= nSecond;
         rLeft   <= nLeft;
         rRight  <= nRight;
         rPrev   <= nPrev;
         rThr    <= nThr;
         rDisp   <= nDisp;
         rRatio  <= nRatio;
         rCnt    <= nCnt;
         rPendR  <= nPendR;
         rOvf    <= nOvf;
         oDone   <= nDone;
         oRes    <= nRes;
      end
   end

endmodule

// File: tb/tb_disparity_wta.sv
// Bench for disparity_wta: directed cases with literal expectations, then
// randomized frames checked against a list-based model of the selector.
module tb_disparity_wta;
   import stereo_pkg::*;

   localparam int MAXD = 64;
   localparam int CW   = 16;
   localparam int ONES = 32'h0000FFFF;

   logic        iClk = 1'b0;
   logic        iReset;
   logic        iClk_en;
   logic        iStart;
   logic [3:0]  iOp;
   logic [31:0] iA;
   logic        oDone;
   logic [31:0] oRes;

   int checks = 0;
   int errors = 0;

   always #5 iClk = ~iClk;

   disparity_wta #(
      .MAX_DISP (MAXD),
      .COST_W   (CW)
   ) dut (
      .iClk    (iClk),
      .iReset  (iReset),
      .iClk_en (iClk_en),
      .iStart  (iStart),
      .iOp     (iOp),
      .iA      (iA),
      .oDone   (oDone),
      .oRes    (oRes)
   );

   // ------------------------------------------------------------ model
   int          mCosts[$];
   bit          mOvf;
   int          mRatio;
   int          mThr;
   logic [31:0] expQ[$];
   logic [31:0] cmpExp;
   logic [3:0]  badOps [8] = '{4'h0, 4'h5, 4'h6, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};

   function automatic logic [31:0] modelRes(input logic [3:0] op);
      int n, best, disp, second, left, right;
      int sorted[$];
      bit valid;
      logic [31:0] r;
      n    = mCosts.size();
      best = ONES;
      disp = 0;
      for (int i = 0; i < n; i++) begin
         if (mCosts[i] < best) begin
            best = mCosts[i];
            disp = i;
         end
      end
      sorted = mCosts;
      sorted.sort();
      second = (n >= 2) ? sorted[1] : ONES;
      left   = (disp > 0) ? mCosts[disp-1] : ONES;
      right  = (n > disp + 1) ? mCosts[disp+1] : ONES;
      valid  = (n != 0) && (best <= mThr) &&
               ((mRatio == 0) || (longint'(16) * second > longint'(16 + mRatio) * best));
      case (op)
         OP_RES:  r = {valid, mOvf, 6'd0, best[15:0], disp[7:0]};
         OP_SEC:  r = second;
         OP_NBR:  r = {left[15:0], right[15:0]};
         OP_CNT:  r = n;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   task automatic modelApply(input logic [3:0] op, input logic [31:0] a);
      case (op)
         OP_CLR: begin
            mCosts.delete();
            mOvf = 1'b0;
         end
         OP_PUSH: begin
            if (mCosts.size() == MAXD) mOvf = 1'b1;
            else mCosts.push_back(int'(a[15:0]));
         end
         OP_RATIO: mRatio = int'(a[7:0]);
         OP_THR:   mThr   = int'(a[15:0]);
         default:  ;
      endcase
   endtask

   task automatic modelReset();
      mCosts.delete();
      mOvf   = 1'b0;
      mRatio = 0;
      mThr   = ONES;
   endtask

   task automatic expectLit(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // ------------------------------------------------------------ compare
   always @(negedge iClk) begin
      if (!iReset && oDone) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: oRes=%h with no instruction outstanding", oRes);
         end else begin
            cmpExp = expQ.pop_front();
            if (oRes !== cmpExp) begin
               errors++;
               $display("FAIL result: got %h, expected %h", oRes, cmpExp);
            end
         end
      end
   end

   // ------------------------------------------------------------ driver
   task automatic runOp(input logic [3:0] op, input logic [31:0] a, input int stall,
                        input bit poke, output logic [31:0] res);
      int n;
      int lat;
      expQ.push_back(modelRes(op));
      modelApply(op, a);
      lat = (op == OP_RES) ? 2 : 1;
      @(negedge iClk);
      iStart = 1'b1;
      iOp    = op;
      iA     = a;
      @(negedge iClk);
      iStart = 1'b0;
      iOp    = 4'($urandom);
      iA     = $urandom;
      n      = 1;
      if (stall > 0) begin
         iClk_en = 1'b0;
         repeat (stall) begin
            @(negedge iClk);
            n++;
         end
         iClk_en = 1'b1;
      end
      while (!oDone && n < lat + stall + 8) begin
         @(negedge iClk);
         n++;
      end
      checks++;
      if (!oDone || n != lat + stall) begin
         errors++;
         $display("FAIL latency op=%h: got %0d cycles (done=%b), expected %0d",
                  op, n, oDone, lat + stall);
         if (!oDone) expQ.delete();
      end
      res = oRes;
      if (poke) begin
         // A start during the completion cycle must be ignored.
         iStart = 1'b1;
         iOp    = OP_CLR;
         @(negedge iClk);
         iStart = 1'b0;
      end
   endtask

   task automatic push(input int c);
      logic [31:0] r;
      runOp(OP_PUSH, 32'(c), 0, 1'b0, r);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      int np;
      int c;
      iReset  = 1'b0;
      iClk_en = 1'b1;
      iStart  = 1'b0;
      iOp     = 4'h0;
      iA      = 32'd0;
      modelReset();
      #1 iReset = 1'b1;
      repeat (2) @(negedge iClk);
      expectLit("reset_oRes", oRes, 32'd0);
      expectLit("reset_oDone", 32'(oDone), 32'd0);
      iReset = 1'b0;

      runOp(OP_CNT, 0, 0, 1'b0, r);  expectLit("reset_cnt", r, 32'd0);
      runOp(OP_RES, 0, 0, 1'b0, r);  expectLit("reset_res", r, 32'h00FFFF00);

      // Basic sequence.
      runOp(OP_CLR, 0, 0, 1'b0, r);
      push(50); push(40); push(30); push(35); push(60);
      runOp(OP_RES, 0, 0, 1'b0, r);  expectLit("basic_res", r, 32'h80001E02);
      runOp(OP_SEC, 0, 0, 1'b0, r);  expectLit("basic_sec", r, 32'd35);
      runOp(OP_NBR, 0, 0, 1'b0, r);  expectLit("basic_nbr", r, 32'h00280023);

      // Ties keep the lowest disparity; ratio gates validity.
      runOp(OP_CLR, 0, 0, 1'b0, r);
      push(20); push(10);
      runOp(OP_PUSH, 32'd10, 0, 1'b1, r);
      runOp(OP_RES, 0, 0, 1'b0, r);  expectLit("tie_res", r, 32'h80000A01);
      runOp(OP_SEC, 0, 0, 1'b0, r);  expectLit("tie_sec", r, 32'd10);
      runOp(OP_RATIO, 4, 0, 1'b0, r);
      runOp(OP_RES, 0, 0, 1'b0, r);  expectLit("ratio4_res", r, 32'h00000A01);
      runOp(OP_RATIO, 0, 0, 1'b0, r);
      runOp(OP_RES, 0, 0, 1'b0, r);  expectLit("ratio0_res", r, 32'h80000A01);

      // Best at the edges.
      runOp(OP_CLR, 0, 0, 1'b0, r);
      push(5); push(9);
      runOp(OP_NBR, 0, 0, 1'b0, r);  expectLit("edge_left", r, 32'hFFFF0009);
      runOp(OP_CLR, 0, 0, 1'b0, r);
      push(9); push(5);
      runOp(OP_NBR, 0, 0, 1'b0, r);  expectLit("edge_right", r, 32'h0009FFFF);

      // Threshold and empty frame.
      runOp(OP_THR, 25, 0, 1'b0, r);
      runOp(OP_CLR, 0, 0, 1'b0, r);
      push(30);
      runOp(OP_RES, 0, 0, 1'b0, r);  expectLit("thr_res", r, 32'h00001E00);
      runOp(OP_THR, 32'hFFFF, 0, 1'b0, r);
      runOp(OP_CLR, 0, 0, 1'b0, r);
      runOp(OP_RES, 0, 0, 1'b0, r);  expectLit("empty_res", r, 32'h00FFFF00);
      runOp(OP_CNT, 0, 0, 1'b0, r);  expectLit("empty_cnt", r, 32'd0);

      // Overflow: the extra push of 0 must be discarded.
      for (int i = 0; i < MAXD; i++) push(100 + ((i * 37) % 61));
      push(0);
      runOp(OP_RES, 0, 0, 1'b0, r);  expectLit("ovf_res", r, 32'hC0006400);
      runOp(OP_CNT, 0, 0, 1'b0, r);  expectLit("ovf_cnt", r, 32'd64);

      // Enable held low during the multiply stage delays completion.
      runOp(OP_CLR, 0, 0, 1'b0, r);
      push(3); push(8);
      runOp(OP_RES, 0, 3, 1'b0, r);  expectLit("stall_res", r, 32'h80000300);

      // Asynchronous reset while OP_RES is in its multiply stage.
      push(7);
      runOp(OP_CNT, 0, 0, 1'b0, r);  expectLit("pre_abort_cnt", r, 32'd3);
      @(negedge iClk);
      iStart = 1'b1;
      iOp    = OP_RES;
      @(negedge iClk);
      iStart = 1'b0;
      #1 iReset = 1'b1;
      #1;
      expectLit("abort_async_oRes", oRes, 32'd0);
      modelReset();
      repeat (3) begin
         @(negedge iClk);
         expectLit("abort_oDone", 32'(oDone), 32'd0);
      end
      iReset = 1'b0;
      repeat (3) begin
         @(negedge iClk);
         expectLit("after_abort_oDone", 32'(oDone), 32'd0);
      end
      runOp(OP_CNT, 0, 0, 1'b0, r);  expectLit("after_abort_cnt", r, 32'd0);

      // Randomized frames against the model.
      for (int f = 0; f < 40; f++) begin
         runOp(OP_CLR, $urandom, 0, 1'b0, r);
         if ($urandom_range(0, 2) == 0)
            runOp(OP_RATIO, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40)),
                  0, 1'b0, r);
         if ($urandom_range(0, 3) == 0)
            runOp(OP_THR, 32'($urandom_range(0, 60)), 0, 1'b0, r);
         else if ($urandom_range(0, 2) == 0)
            runOp(OP_THR, 32'hFFFF, 0, 1'b0, r);
         np = ($urandom_range(0, 4) == 0) ? $urandom_range(MAXD - 2, MAXD + 2)
                                          : $urandom_range(0, 20);
         for (int k = 0; k < np; k++) begin
            c = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 16'hFFFE) : $urandom_range(0, 60);
            runOp(OP_PUSH, ($urandom() << 16) | 32'(c), 0, 1'b0, r);
         end
         runOp(OP_RES, 0, $urandom_range(0, 2), 1'b0, r);
         runOp(OP_SEC, 0, 0, 1'b0, r);
         runOp(OP_NBR, 0, 0, 1'b0, r);
         runOp(OP_CNT, 0, 0, 1'b0, r);
         runOp(badOps[$urandom_range(0, 7)], $urandom, 0, 1'b0, r);
      end

      repeat (2) @(negedge iClk);
      expectLit("queue_drained", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
